trdb_branch_map_reader: RTL and testbench

TRDB_BRANCH_MAP_READER -- requirements
Module: trdb_branch_map_reader

---
 rtl/trdb_pkg.sv | 17 +
 rtl/trdb_branch_map_reader.sv | 82 ++++++++
 tb/tb_trdb_branch_map_reader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/trdb_pkg.sv
// Shared trace-debug branch-map definitions used by both the encoder and the
// reader so the two ends agree on map length and count encoding.
package trdb_pkg;

  localparam int MAP_LEN_DEF = 31;
  localparam int CNT_W_DEF   = $clog2(MAP_LEN_DEF + 1);

  // Encoder side: a branch count field of 0 means "full map".
  localparam int ENC_FULL_MAP_CODE = 0;
  localparam int ENC_MAP_FLUSH_MIN = MAP_LEN_DEF;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } bmap_state_e;

endpackage

// File: rtl/trdb_branch_map_reader.sv
// Holds one packet's branch map and hands out taken/not-taken outcomes,
// oldest first, one per consumer request.
module trdb_branch_map_reader
  import trdb_pkg::*;
#(
  parameter int MAP_LEN = MAP_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_valid_i,
  output logic               load_ready_o,
  input  logic [MAP_LEN-1:0] load_map_i,
  input  logic [CNT_W-1:0]   load_branches_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  output logic               taken_o,
  input  logic               flush_i,
  output logic [CNT_W:0]     remaining_o,
  output logic               is_empty_o,
  output logic               underflow_o
);

  localparam logic [CNT_W:0] MAP_LEN_C = (CNT_W+1)'(MAP_LEN);

  bmap_state_e        state_q, state_d;
  logic [MAP_LEN-1:0] map_q, map_d;
  logic [CNT_W:0]     rem_q, rem_d;
  logic [CNT_W:0]     load_cnt;
  logic               pop, load_hs;

  // Count 0 encodes a full map; anything out of range is clamped too.
  always_comb begin
    load_cnt = {1'b0, load_branches_i};
    if (load_cnt == '0 || load_cnt > MAP_LEN_C) load_cnt = MAP_LEN_C;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      map_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      rem_q   <= rem_d;
    end
  end

  // Priority: flush, then load (which also wins over a last-outcome pop), then pop.
  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    rem_d   = rem_q;
    if (flush_i) begin
      state_d = EMPTY;
      map_d   = '0;
      rem_d   = '0;
    end else if (load_hs) begin
      state_d = HOLD;
      map_d   = load_map_i;
      rem_d   = load_cnt;
    end else if (pop) begin
      map_d   = {1'b0, map_q[MAP_LEN-1:1]};
      rem_d   = rem_q - 1'b1;
      state_d = (rem_q == (CNT_W+1)'(1)) ? EMPTY : HOLD;
    end
  end

  always_comb begin
    req_ready_o  = (state_q == HOLD);
    pop          = req_valid_i && req_ready_o && !flush_i;
    load_ready_o = !flush_i &&
                   ((state_q == EMPTY) || (rem_q == (CNT_W+1)'(1) && pop));
    load_hs      = load_valid_i && load_ready_o;
    taken_o      = req_ready_o && map_q[0];
    underflow_o  = rst_ni && req_valid_i && (state_q == EMPTY) && !flush_i;
    remaining_o  = rem_q;
    is_empty_o   = (rem_q == '0);
  end

endmodule

// File: tb/tb_trdb_branch_map_reader.sv
// Directed checks of the branch-map reader with hand-computed expectations.
module tb_trdb_branch_map_reader;

  localparam int MAP_LEN = 31;
  localparam int CNT_W   = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               load_valid, load_ready;
  logic [MAP_LEN-1:0] load_map;
  logic [CNT_W-1:0]   load_branches;
  logic               req_valid, req_ready, taken, flush;
  logic [CNT_W:0]     remaining;
  logic               is_empty, underflow;

  int n_chk = 0;
  int n_err = 0;

  trdb_branch_map_reader #(.MAP_LEN(MAP_LEN), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .load_valid_i   (load_valid),
    .load_ready_o   (load_ready),
    .load_map_i     (load_map),
    .load_branches_i(load_branches),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .taken_o        (taken),
    .flush_i        (flush),
    .remaining_o    (remaining),
    .is_empty_o     (is_empty),
    .underflow_o    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_valid = 1'b0; req_valid = 1'b0; flush = 1'b0;
    #1;
  endtask

  task automatic load(input logic [MAP_LEN-1:0] m, input logic [CNT_W-1:0] b);
    load_valid = 1'b1; load_map = m; load_branches = b;
    step();
    load_valid = 1'b0;
    #1;
  endtask

  initial begin
    logic [3:0] exp4;
    rst_n = 1'b0; load_valid = 1'b0; req_valid = 1'b0; flush = 1'b0;
    load_map = '0; load_branches = '0;
    step();
    chk("rst_load_ready", 32'(load_ready), 1);
    chk("rst_req_ready",  32'(req_ready),  0);
    chk("rst_taken",      32'(taken),      0);
    chk("rst_remaining",  32'(remaining),  0);
    chk("rst_is_empty",   32'(is_empty),   1);
    chk("rst_underflow",  32'(underflow),  0);
    rst_n = 1'b1;
    step();

    // Map 0b1011, 4 branches: outcomes 1,1,0,1
    exp4 = 4'b1011;
    load(31'b1011, 5'd4);
    chk("l4_remaining", 32'(remaining), 4);
    chk("l4_is_empty",  32'(is_empty),  0);
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; #1;
      chk("l4_taken",   32'(taken),     32'(exp4[i]));
      chk("l4_rem_seq", 32'(remaining), 32'(4 - i));
      step();
    end
    idle();
    chk("l4_rem_end",   32'(remaining), 0);
    chk("l4_empty_end", 32'(is_empty),  1);

    // Full map via branches=0
    load({MAP_LEN{1'b1}}, 5'd0);
    chk("full_remaining", 32'(remaining), 31);
    for (int i = 0; i < 31; i++) begin
      req_valid = 1'b1; #1;
      chk("full_taken", 32'(taken), 1);
      step();
    end
    chk("full_rem_end",  32'(remaining), 0);
    chk("full_underflow", 32'(underflow), 1);
    chk("full_req_ready", 32'(req_ready), 0);
    step();
    chk("full_rem_stay", 32'(remaining), 0);
    idle();
    chk("full_uf_clear", 32'(underflow), 0);

    // Last pop with simultaneous load: load wins
    load(31'b10, 5'd1);
    chk("pl_rem_pre", 32'(remaining), 1);
    req_valid = 1'b1; load_valid = 1'b1; load_map = 31'b1; load_branches = 5'd1; #1;
    chk("pl_taken_now",  32'(taken),      0);
    chk("pl_load_ready", 32'(load_ready), 1);
    step();
    idle();
    chk("pl_rem_next",   32'(remaining), 1);
    chk("pl_taken_next", 32'(taken),     1);
    req_valid = 1'b1; step(); idle();
    chk("pl_drained", 32'(remaining), 0);

    // Load refused while holding 2 without a pop
    load(31'b01, 5'd2);
    load_valid = 1'b1; load_map = 31'b10; load_branches = 5'd5; #1;
    chk("hold_load_ready", 32'(load_ready), 0);
    step();
    idle();
    chk("hold_rem",   32'(remaining), 2);
    chk("hold_taken", 32'(taken),     1);
    req_valid = 1'b1; step(); idle();
    chk("hold_taken2", 32'(taken),     0);
    chk("hold_rem2",   32'(remaining), 1);
    req_valid = 1'b1; step(); idle();

    // Flush beats pop and load, no underflow
    load(31'b11111, 5'd5);
    chk("fl_rem_pre", 32'(remaining), 5);
    flush = 1'b1; req_valid = 1'b1; load_valid = 1'b1;
    load_map = 31'b1; load_branches = 5'd1; #1;
    chk("fl_load_ready", 32'(load_ready), 0);
    chk("fl_underflow",  32'(underflow),  0);
    step();
    idle();
    chk("fl_rem",        32'(remaining),  0);
    chk("fl_load_ready2", 32'(load_ready), 1);
    chk("fl_req_ready",  32'(req_ready),  0);
    chk("fl_is_empty",   32'(is_empty),   1);

    // Asynchronous reset mid-cycle while holding 3
    load(31'b111, 5'd3);
    chk("ar_rem_pre", 32'(remaining), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_remaining",  32'(remaining),  0);
    chk("ar_req_ready",  32'(req_ready),  0);
    chk("ar_taken",      32'(taken),      0);
    chk("ar_is_empty",   32'(is_empty),   1);
    chk("ar_load_ready", 32'(load_ready), 1);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_rem_after", 32'(remaining), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
